alu_control_sequencer: RTL and testbench

- Hardwired control unit for register-format ALU instructions.
- Drives the datapath's control strobes through fetch (T0–T2) and execute (T3–T5/T6) phases, decoding the opcode and register fields from the instruction register.
- Takes over the role the stimulus benches play today, so the datapath can run instructions autonomously.
- Sits between the datapath's IR output and all datapath control inputs.

---
 rtl/alu_control_sequencer_if.sv | 52 +++++
 rtl/alu_control_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_sequencer_if.sv
// Control bus between alu_control_sequencer and the register-format datapath.
//
// Purpose: bundles the sequencer's inputs (Run level, instruction register)
// and every datapath control strobe into a single port.
//
// Signals:
//   Run                    level, high starts/continues execution
//   IR[31:0]               instruction register contents from the datapath
//   PCout PCin IncPC MARin program counter / MAR strobes
//   Read MDRin MDRout IRin memory data register / IR strobes
//   Yin ZLowIn ZHighIn     ALU operand and result register load strobes
//   Zlowout ZHighout       result register drive strobes
//   HIin LOin              HI/LO load strobes
//   Rin[NREGS-1:0]         one-hot general register load enables
//   Rout[NREGS-1:0]        one-hot general register drive enables
//   ALUop[4:0]             ALU operation code
//   Done Illegal           end-of-instruction / unsupported-opcode pulses
//
// Modports:
//   master  the sequencer (drives strobes, reads Run/IR)
//   slave   the datapath or bench (drives Run/IR, reads strobes)

interface alu_control_sequencer_if #(
   parameter int NREGS = 16
);
   logic              Run;
   logic [31:0]       IR;
   logic              PCout, PCin, IncPC, MARin;
   logic              Read, MDRin, MDRout, IRin;
   logic              Yin, ZLowIn, ZHighIn, Zlowout, ZHighout;
   logic              HIin, LOin;
   logic [NREGS-1:0]  Rin;
   logic [NREGS-1:0]  Rout;
   logic [4:0]        ALUop;
   logic              Done, Illegal;

   modport master (
      input  Run, IR,
      output PCout, PCin, IncPC, MARin,
      output Read, MDRin, MDRout, IRin,
      output Yin, ZLowIn, ZHighIn, Zlowout, ZHighout,
      output HIin, LOin, Rin, Rout, ALUop, Done, Illegal
   );

   modport slave (
      output Run, IR,
      input  PCout, PCin, IncPC, MARin,
      input  Read, MDRin, MDRout, IRin,
      input  Yin, ZLowIn, ZHighIn, Zlowout, ZHighout,
      input  HIin, LOin, Rin, Rout, ALUop, Done, Illegal
   );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit for register-format ALU instructions.
//
// Purpose: steps the datapath through instruction fetch (T0-T2) and execute
// (T3-T5, plus T6 for MUL/DIV), decoding opcode/Ra/Rb/Rc from IR and raising
// the matching control strobes. Outputs are a combinational decode of the
// state register and IR.
//
// Ports:
//   Clock  in   system clock, rising-edge active
//   Clear  in   asynchronous active-high reset, forces IDLE (all outputs 0)
//   bus    master modport of alu_control_sequencer_if (Run, IR, strobes)
//
// States:
//   state | meaning
//   IDLE  | waiting for Run, all strobes low
//   T0    | PC -> MAR, PC incremented
//   T1    | memory read into MDR
//   T2    | MDR -> IR
//   T3    | Rc -> Y (or Illegal pulse for an unsupported opcode)
//   T4    | Rb op Y -> Z (low, and high for MUL/DIV)
//   T5    | Zlow -> Ra and Done, or Zlow -> LO for MUL/DIV
//   T6    | Zhigh -> HI and Done (MUL/DIV only)

module alu_control_sequencer #(
   parameter int NREGS = 16
) (
   input  logic                     Clock,
   input  logic                     Clear,
   alu_control_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_T6   = 3'd7
   } state_t;

   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   state_t state_q, state_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       op_legal, op_wide;
   logic [NREGS-1:0] sel_ra, sel_rb, sel_rc;

   logic pc_out, pc_in, inc_pc, mar_in;
   logic mem_read, mdr_in, mdr_out, ir_in;
   logic y_in, zlo_in, zhi_in, zlo_out, zhi_out;
   logic hi_in, lo_in, done, illegal;
   logic [NREGS-1:0] rin, rout;
   logic [4:0] alu_op;

   // Low IR bits carry no meaning for register-format instructions.
   logic unused_ir_bits;
   assign unused_ir_bits = ^bus.IR[14:0];

   // A register index beyond NREGS selects nothing rather than wrapping.
   function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
      logic [NREGS-1:0] sel;
      sel = '0;
      for (int i = 0; i < NREGS; i++) begin
         sel[i] = (32'(idx) == i);
      end
      return sel;
   endfunction

   assign opcode = bus.IR[31:27];
   assign ra     = bus.IR[26:23];
   assign rb     = bus.IR[22:19];
   assign rc     = bus.IR[18:15];

   assign sel_ra = reg_sel(ra);
   assign sel_rb = reg_sel(rb);
   assign sel_rc = reg_sel(rc);

   always_comb begin
      op_wide  = (opcode == OP_MUL) || (opcode == OP_DIV);
      op_legal = op_wide || ((opcode >= 5'b00011) && (opcode <= 5'b01011));
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_out   = 1'b0;
      pc_in    = 1'b0;
      inc_pc   = 1'b0;
      mar_in   = 1'b0;
      mem_read = 1'b0;
      mdr_in   = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      y_in     = 1'b0;
      zlo_in   = 1'b0;
      zhi_in   = 1'b0;
      zlo_out  = 1'b0;
      zhi_out  = 1'b0;
      hi_in    = 1'b0;
      lo_in    = 1'b0;
      done     = 1'b0;
      illegal  = 1'b0;
      rin      = '0;
      rout     = '0;
      alu_op   = 5'b00000;

      case (state_q)
         S_IDLE: begin
            if (bus.Run) state_d = S_T0;
         end
         S_T0: begin
            pc_out  = 1'b1;
            mar_in  = 1'b1;
            inc_pc  = 1'b1;
            pc_in   = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            mem_read = 1'b1;
            mdr_in   = 1'b1;
            state_d  = S_T2;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            // First state where IR is trusted; it was loaded at the end of T2.
            if (op_legal) begin
               rout    = sel_rc;
               y_in    = 1'b1;
               state_d = S_T4;
            end else begin
               illegal = 1'b1;
               state_d = bus.Run ? S_T0 : S_IDLE;
            end
         end
         S_T4: begin
            rout    = sel_rb;
            alu_op  = opcode;
            zlo_in  = 1'b1;
            zhi_in  = op_wide;
            state_d = S_T5;
         end
         S_T5: begin
            zlo_out = 1'b1;
            if (op_wide) begin
               lo_in   = 1'b1;
               state_d = S_T6;
            end else begin
               rin     = sel_ra;
               done    = 1'b1;
               state_d = bus.Run ? S_T0 : S_IDLE;
            end
         end
         S_T6: begin
            zhi_out = 1'b1;
            hi_in   = 1'b1;
            done    = 1'b1;
            state_d = bus.Run ? S_T0 : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.PCout    = pc_out;
   assign bus.PCin     = pc_in;
   assign bus.IncPC    = inc_pc;
   assign bus.MARin    = mar_in;
   assign bus.Read     = mem_read;
   assign bus.MDRin    = mdr_in;
   assign bus.MDRout   = mdr_out;
   assign bus.IRin     = ir_in;
   assign bus.Yin      = y_in;
   assign bus.ZLowIn   = zlo_in;
   assign bus.ZHighIn  = zhi_in;
   assign bus.Zlowout  = zlo_out;
   assign bus.ZHighout = zhi_out;
   assign bus.HIin     = hi_in;
   assign bus.LOin     = lo_in;
   assign bus.Rin      = rin;
   assign bus.Rout     = rout;
   assign bus.ALUop    = alu_op;
   assign bus.Done     = done;
   assign bus.Illegal  = illegal;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: per-cycle expected strobe vectors are
// queued when an instruction is issued and compared at each falling edge.

module tb_alu_control_sequencer;

   localparam int NREGS = 16;

   logic Clock = 1'b0;
   logic Clear;

   always #5 Clock = ~Clock;

   alu_control_sequencer_if #(.NREGS(NREGS)) bus ();

   alu_control_sequencer #(.NREGS(NREGS)) dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   typedef struct packed {
      logic pc_out, pc_in, inc_pc, mar_in;
      logic rd, mdr_in, mdr_out, ir_in;
      logic y_in, zlo_in, zhi_in, zlo_out, zhi_out;
      logic hi_in, lo_in, done, illegal;
      logic [4:0]  alu_op;
      logic [15:0] rin;
      logic [15:0] rout;
   } ctl_t;

   typedef struct {
      ctl_t        vec;
      string       tag;
      logic [31:0] ir_next;
      logic        run_next;
   } step_t;

   localparam logic [31:0] JUNK_IR = 32'hFFFF_FFFF;

   step_t sb_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic ctl_t sample_bus();
      ctl_t c;
      c.pc_out  = bus.PCout;   c.pc_in   = bus.PCin;
      c.inc_pc  = bus.IncPC;   c.mar_in  = bus.MARin;
      c.rd      = bus.Read;    c.mdr_in  = bus.MDRin;
      c.mdr_out = bus.MDRout;  c.ir_in   = bus.IRin;
      c.y_in    = bus.Yin;     c.zlo_in  = bus.ZLowIn;
      c.zhi_in  = bus.ZHighIn; c.zlo_out = bus.Zlowout;
      c.zhi_out = bus.ZHighout;
      c.hi_in   = bus.HIin;    c.lo_in   = bus.LOin;
      c.done    = bus.Done;    c.illegal = bus.Illegal;
      c.alu_op  = bus.ALUop;
      c.rin     = bus.Rin;     c.rout    = bus.Rout;
      return c;
   endfunction

   function automatic logic [31:0] make_ir(input logic [4:0] op, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'h2A5A};
   endfunction

   function automatic logic [15:0] onehot(input logic [3:0] idx);
      logic [15:0] v;
      v = 16'h0001;
      return v << idx;
   endfunction

   // Queue the expected strobe vector for every state of one instruction.
   // run_mid is driven during all but the last state, run_end during the last.
   task automatic push_instr(input string name, input logic [31:0] ir,
                             input logic run_mid, input logic run_end);
      logic [4:0] op;
      logic       legal, wide;
      int         n;
      op    = ir[31:27];
      wide  = (op == 5'd15) || (op == 5'd16);
      legal = wide || (op inside {[5'd3:5'd11]});
      n     = !legal ? 4 : (wide ? 7 : 6);
      for (int k = 0; k < n; k++) begin
         step_t s;
         s.vec = '0;
         case (k)
            0: begin s.vec.pc_out = 1; s.vec.mar_in = 1; s.vec.inc_pc = 1; s.vec.pc_in = 1; end
            1: begin s.vec.rd = 1; s.vec.mdr_in = 1; end
            2: begin s.vec.mdr_out = 1; s.vec.ir_in = 1; end
            3: begin
               if (legal) begin
                  s.vec.rout = onehot(ir[18:15]);
                  s.vec.y_in = 1;
               end else begin
                  s.vec.illegal = 1;
               end
            end
            4: begin
               s.vec.rout   = onehot(ir[22:19]);
               s.vec.alu_op = op;
               s.vec.zlo_in = 1;
               s.vec.zhi_in = wide;
            end
            5: begin
               s.vec.zlo_out = 1;
               if (wide) s.vec.lo_in = 1;
               else begin
                  s.vec.rin  = onehot(ir[26:23]);
                  s.vec.done = 1;
               end
            end
            default: begin s.vec.zhi_out = 1; s.vec.hi_in = 1; s.vec.done = 1; end
         endcase
         s.tag      = $sformatf("%s_T%0d", name, k);
         s.ir_next  = (k >= 2 && k < n - 1) ? ir : JUNK_IR;
         s.run_next = (k == n - 1) ? run_end : run_mid;
         sb_q.push_back(s);
      end
   endtask

   task automatic tick();
      step_t s;
      @(negedge Clock);
      check_eq("rin_rout_excl", {63'b0, (|bus.Rin) && (|bus.Rout)}, 64'd0);
      check_eq("onehot", {63'b0, ($countones(bus.Rin) > 1) || ($countones(bus.Rout) > 1)}, 64'd0);
      if (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         check_eq(s.tag, 64'(sample_bus()), 64'(s.vec));
         bus.IR  = s.ir_next;
         bus.Run = s.run_next;
      end else begin
         check_eq("idle", 64'(sample_bus()), 64'd0);
      end
   endtask

   task automatic drain();
      while (sb_q.size() > 0) tick();
   endtask

   int cyc;
   int done_cyc[$];
   step_t s_t4;

   initial begin
      Clear   = 1'b1;
      bus.Run = 1'b0;
      bus.IR  = 32'h0;
      #2;
      check_eq("clear_outs", 64'(sample_bus()), 64'd0);
      @(negedge Clock);
      Clear = 1'b0;
      repeat (2) tick();

      // OR R4 <- R3 | R7, Run dropped in the last state
      bus.Run = 1'b1; bus.IR = JUNK_IR;
      push_instr("or", 32'h321B8000, 1'b1, 1'b0);
      drain();
      repeat (2) tick();

      // MUL with Run dropped right after issue: must still complete
      bus.Run = 1'b1; bus.IR = JUNK_IR;
      push_instr("mul", make_ir(5'd15, 4'd1, 4'd2, 4'd5), 1'b0, 1'b0);
      drain();
      repeat (2) tick();

      // Illegal opcode followed immediately by aliased ADD R9 <- R9 + R9
      bus.Run = 1'b1; bus.IR = JUNK_IR;
      push_instr("ill", make_ir(5'd31, 4'd1, 4'd2, 4'd3), 1'b1, 1'b1);
      push_instr("alias", make_ir(5'd3, 4'd9, 4'd9, 4'd9), 1'b1, 1'b0);
      drain();
      tick();

      // Back-to-back ADDs, Done expected in cycles 6 and 12
      bus.Run = 1'b1; bus.IR = JUNK_IR;
      push_instr("add1", make_ir(5'd3, 4'd1, 4'd2, 4'd3), 1'b1, 1'b1);
      push_instr("add2", make_ir(5'd3, 4'd4, 4'd5, 4'd6), 1'b1, 1'b0);
      cyc = 0;
      while (sb_q.size() > 0) begin
         tick();
         cyc++;
         if (bus.Done) done_cyc.push_back(cyc);
      end
      check_eq("b2b_done_count", 64'(done_cyc.size()), 64'd2);
      if (done_cyc.size() == 2) begin
         check_eq("b2b_done_first", 64'(done_cyc[0]), 64'd6);
         check_eq("b2b_done_second", 64'(done_cyc[1]), 64'd12);
      end
      tick();

      // Mixed ops back-to-back: SUB, DIV, ROL, SHRA
      bus.Run = 1'b1; bus.IR = JUNK_IR;
      push_instr("sub",  make_ir(5'd4,  4'd0,  4'd15, 4'd8), 1'b1, 1'b1);
      push_instr("div",  make_ir(5'd16, 4'd6,  4'd7,  4'd14), 1'b1, 1'b1);
      push_instr("rol",  make_ir(5'd11, 4'd15, 4'd0,  4'd1), 1'b1, 1'b1);
      push_instr("shra", make_ir(5'd8,  4'd2,  4'd13, 4'd11), 1'b0, 1'b0);
      drain();
      repeat (2) tick();

      // Asynchronous Clear in the middle of T4
      bus.Run = 1'b1; bus.IR = JUNK_IR;
      push_instr("clr", make_ir(5'd4, 4'd2, 4'd3, 4'd4), 1'b1, 1'b1);
      repeat (4) tick();
      @(posedge Clock);
      #2;
      s_t4 = sb_q.pop_front();
      check_eq(s_t4.tag, 64'(sample_bus()), 64'(s_t4.vec));
      Clear = 1'b1;
      #1;
      check_eq("clear_mid_t4", 64'(sample_bus()), 64'd0);
      sb_q.delete();
      bus.Run = 1'b0;
      @(negedge Clock);
      Clear = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
